mmio_uart_tx: RTL

Memory-mapped UART transmitter on the CPU data port. It decodes the CPU's combinational data address, write data and byte-enables, and accepts stores into a transmit FIFO. It serialises queued bytes as 8N1 frames on a single `tx` pin. It returns status and divisor values combinationally on `data_rd`, so a load completes in the same cycle it is issued.

---
 rtl/mmio_pkg.sv | 33 +++
 rtl/sync_fifo.sv | 73 +++++++
 rtl/mmio_uart_tx.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mmio_pkg
// Description : Shared definitions for the memory-mapped UART transmitter:
//               register offsets (data_addr[3:2]), STATUS bit positions and
//               the transmit FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package mmio_pkg;

    // Register offsets, indexed by data_addr[3:2]
    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DIV    = 2'd2;
    localparam logic [1:0] REG_RSVD   = 2'd3;

    // STATUS register bit positions
    localparam int STAT_FULL    = 0;
    localparam int STAT_BUSY    = 1;
    localparam int STAT_EMPTY   = 2;
    localparam int STAT_OVF     = 3;
    localparam int STAT_CNT_LSB = 8;

    // Transmit FSM states
    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } uart_tx_state_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO, 2**AW entries of WIDTH bits, first-word
//               fall-through read (o_data shows the head entry).
//               A push while full and a pop while empty are ignored; a push
//               is judged against the fullness before the edge, so a
//               simultaneous pop never makes room for it.
// Ports       : clk, rst (sync, active high), push, pop, i_data, o_data,
//               full, empty, count (AW+1 bits)
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    localparam int        c_DEPTH = 1 << AW;
    localparam logic [AW:0] c_FULL = (AW + 1)'(c_DEPTH);

    logic [WIDTH-1:0] r_mem [c_DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == c_FULL);
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    // Storage carries no reset; validity is tracked by the count.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/mmio_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : mmio_uart_tx
// Description : Memory-mapped 8N1 UART transmitter on the CPU data port.
//               16-byte window at BASE_ADDR: TXDATA (push), STATUS (full,
//               busy, empty, overflow W1C, count), DIV (clocks per bit).
//               Reads are combinational so a load completes in its cycle.
// Config      : MMIO_UART_TX_FIFO_EN defined  -> sync_fifo of 2**FIFO_AW
//               entries; undefined -> single holding register.
// Ports       : clk, rst (sync, active high)
//               data_addr, data_wr, data_wr_en  - CPU store/load request
//               data_rd, hit                    - combinational response
//               tx                              - serial output, idles high
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_uart_tx
    import mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
    parameter logic [15:0] DIV_RESET = 16'd868,
    parameter int          FIFO_AW   = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wr,
    input  logic [3:0]  data_wr_en,
    output logic [31:0] data_rd,
    output logic        hit,
    output logic        tx
);

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic       w_hit;
    logic       w_wr;
    logic [1:0] w_off;
    logic       w_push_req;
    logic       w_ovf_clr;
    logic       w_unused;

    assign w_hit      = (data_addr[31:4] == BASE_ADDR[31:4]);
    assign w_off      = data_addr[3:2];
    assign w_wr       = w_hit && (data_wr_en != 4'b0000);
    assign w_push_req = w_wr && (w_off == REG_TXDATA) && data_wr_en[0];
    assign w_ovf_clr  = w_wr && (w_off == REG_STATUS) && data_wr_en[0]
                        && data_wr[STAT_OVF];
    assign hit        = w_hit;
    assign w_unused   = &{1'b0, data_addr[1:0], data_wr[31:16]};

    // ------------------------------------------------------------------
    // Transmit queue
    // ------------------------------------------------------------------
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic [FIFO_AW:0]   w_count;
    logic [7:0]         w_fifo_data;

`ifdef MMIO_UART_TX_FIFO_EN
    sync_fifo #(
        .WIDTH (8),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (w_push_req),
        .pop    (w_pop),
        .i_data (data_wr[7:0]),
        .o_data (w_fifo_data),
        .full   (w_full),
        .empty  (w_empty),
        .count  (w_count)
    );
`else
    logic       r_hold_valid;
    logic [7:0] r_hold_data;

    // Push is only taken when the register was empty before the edge, so a
    // same-cycle pop of a full holding register still drops the push.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_valid <= 1'b0;
        end else begin
            if (w_pop) begin
                r_hold_valid <= 1'b0;
            end
            if (w_push_req && !r_hold_valid) begin
                r_hold_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_req && !r_hold_valid) begin
            r_hold_data <= data_wr[7:0];
        end
    end

    assign w_full      = r_hold_valid;
    assign w_empty     = !r_hold_valid;
    assign w_count     = {{FIFO_AW{1'b0}}, r_hold_valid};
    assign w_fifo_data = r_hold_data;
`endif

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    logic [15:0] r_div;
    logic        r_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div <= DIV_RESET;
            r_ovf <= 1'b0;
        end else begin
            if (w_wr && (w_off == REG_DIV)) begin
                if (data_wr_en[0]) r_div[7:0]  <= data_wr[7:0];
                if (data_wr_en[1]) r_div[15:8] <= data_wr[15:8];
            end
            // A dropped push wins over a simultaneous clear.
            if (w_push_req && w_full) begin
                r_ovf <= 1'b1;
            end else if (w_ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Transmit FSM
    // ------------------------------------------------------------------
    uart_tx_state_t r_state;
    uart_tx_state_t w_state_next;
    logic [15:0]    r_baud;
    logic [15:0]    w_baud_next;
    logic [2:0]     r_bit;
    logic [2:0]     w_bit_next;
    logic [7:0]     r_shift;
    logic [7:0]     w_shift_next;
    logic [15:0]    r_divq;
    logic [15:0]    w_divq_next;
    logic           r_tx;
    logic           w_tx_next;
    logic [15:0]    w_div_eff;
    logic           w_baud_done;

    // A stored divisor of 0 behaves as 1 clock per bit.
    assign w_div_eff   = (r_div == 16'd0) ? 16'd1 : r_div;
    assign w_baud_done = (r_baud == (r_divq - 16'd1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= TX_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_divq  <= 16'd1;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_baud  <= w_baud_next;
            r_bit   <= w_bit_next;
            r_shift <= w_shift_next;
            r_divq  <= w_divq_next;
            r_tx    <= w_tx_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_baud_next  = r_baud;
        w_bit_next   = r_bit;
        w_shift_next = r_shift;
        w_divq_next  = r_divq;
        w_pop        = 1'b0;

        case (r_state)
            TX_IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_shift_next = w_fifo_data;
                    w_divq_next  = w_div_eff;
                    w_baud_next  = '0;
                    w_state_next = TX_START;
                end
            end
            TX_START: begin
                if (w_baud_done) begin
                    w_baud_next  = '0;
                    w_bit_next   = '0;
                    w_state_next = TX_DATA;
                end else begin
                    w_baud_next = r_baud + 16'd1;
                end
            end
            TX_DATA: begin
                if (w_baud_done) begin
                    w_baud_next  = '0;
                    w_shift_next = {1'b0, r_shift[7:1]};
                    w_bit_next   = r_bit + 3'd1;
                    if (r_bit == 3'd7) begin
                        w_state_next = TX_STOP;
                    end
                end else begin
                    w_baud_next = r_baud + 16'd1;
                end
            end
            TX_STOP: begin
                if (w_baud_done) begin
                    w_baud_next = '0;
                    // Chain straight into the next start bit when data waits.
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_shift_next = w_fifo_data;
                        w_divq_next  = w_div_eff;
                        w_state_next = TX_START;
                    end else begin
                        w_state_next = TX_IDLE;
                    end
                end else begin
                    w_baud_next = r_baud + 16'd1;
                end
            end
            default: begin
                w_state_next = TX_IDLE;
            end
        endcase

        // Registered line level derived from the state being entered.
        case (w_state_next)
            TX_START: w_tx_next = 1'b0;
            TX_DATA:  w_tx_next = w_shift_next[0];
            default:  w_tx_next = 1'b1;
        endcase
    end

    assign tx = r_tx;

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    logic [31:0] w_status;

    assign w_status = {16'b0, 8'(w_count), 4'b0, r_ovf, w_empty,
                       (r_state != TX_IDLE), w_full};

    always_comb begin
        data_rd = 32'd0;
        if (w_hit) begin
            case (w_off)
                REG_STATUS: data_rd = w_status;
                REG_DIV:    data_rd = {16'b0, r_div};
                default:    data_rd = 32'd0;
            endcase
        end
    end

endmodule
`default_nettype wire
